// File: rtl/ka163_mul_arbiter_if.sv
// Handshake and operand/result bus between requesters, the arbiter and the multiplier.
interface ka163_mul_arbiter_if;
    localparam int unsigned OP_W  = 163;
    localparam int unsigned RES_W = 325;

    logic             req0_valid;
    logic             req0_ready;
    logic [OP_W-1:0]  req0_a;
    logic [OP_W-1:0]  req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [OP_W-1:0]  req1_a;
    logic [OP_W-1:0]  req1_b;
    logic [OP_W-1:0]  mul_a;
    logic [OP_W-1:0]  mul_b;
    logic [RES_W-1:0] mul_y;
    logic             res_valid;
    logic             res_ready;
    logic [RES_W-1:0] res_y;
    logic             res_id;
    logic             busy;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        output mul_a, mul_b,
        input  mul_y,
        output res_valid, res_y, res_id,
        input  res_ready,
        output busy
    );

    // Requester / consumer / multiplier side
    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        input  mul_a, mul_b,
        output mul_y,
        input  res_valid, res_y, res_id,
        output res_ready,
        input  busy
    );
endinterface

// File: rtl/ka163_mul_arbiter.sv
// Round-robin sequencer sharing one combinational 163-bit carry-less multiplier
// between two requesters, holding operands MUL_CYCLES cycles before capture.
module ka163_mul_arbiter #(
    parameter int unsigned MUL_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    ka163_mul_arbiter_if.slave  bus
);
    localparam int unsigned OP_W  = 163;
    localparam int unsigned RES_W = 325;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [OP_W-1:0]  mul_a_q, mul_a_d;
    logic [OP_W-1:0]  mul_b_q, mul_b_d;
    logic [RES_W-1:0] res_y_q, res_y_d;
    logic             res_valid_q, res_valid_d;
    logic             res_id_q, res_id_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             idle_c;
    logic             grant_c;
    logic             rdy0_c;
    logic             rdy1_c;

    assign idle_c = (state_q == S_IDLE);

    // Round-robin grant: on a tie serve the requester that was not served last
    always_comb begin
        grant_c = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_c = ~last_q;
        end else begin
            grant_c = bus.req1_valid;
        end
    end

    assign rdy0_c = idle_c && !grant_c && bus.req0_valid;
    assign rdy1_c = idle_c &&  grant_c && bus.req1_valid;

    assign bus.req0_ready = rdy0_c;
    assign bus.req1_ready = rdy1_c;
    assign bus.mul_a      = mul_a_q;
    assign bus.mul_b      = mul_b_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_y      = res_y_q;
    assign bus.res_id     = res_id_q;
    assign bus.busy       = !idle_c;

    // Next-state and datapath updates
    always_comb begin
        state_d     = state_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        res_y_d     = res_y_q;
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (rdy0_c || rdy1_c) begin
                    mul_a_d  = grant_c ? bus.req1_a : bus.req0_a;
                    mul_b_d  = grant_c ? bus.req1_b : bus.req0_b;
                    res_id_d = grant_c;
                    last_d   = grant_c;
                    cnt_d    = CNT_W'(MUL_CYCLES - 1);
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    res_y_d     = bus.mul_y;
                    res_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; pointer resets to 1 so requester 0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            res_y_q     <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            res_y_q     <= res_y_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
        end
    end
endmodule

// File: tb/tb_ka163_mul_arbiter.sv
// Scoreboard bench for ka163_mul_arbiter: one instance with MUL_CYCLES=2, one with 4.
module tb_ka163_mul_arbiter;
    localparam int unsigned MC2 = 2;
    localparam int unsigned MC4 = 4;

    typedef struct packed {
        logic [324:0] y;
        logic         id;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    exp_t sb_q[$];

    ka163_mul_arbiter_if b2();
    ka163_mul_arbiter_if b4();

    ka163_mul_arbiter #(.MUL_CYCLES(MC2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    ka163_mul_arbiter #(.MUL_CYCLES(MC4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

    // Reference carry-less multiplier standing in for the Karatsuba instance
    function automatic logic [324:0] clmul(input logic [162:0] a, input logic [162:0] b);
        logic [324:0] r;
        r = '0;
        for (int i = 0; i < 163; i++) begin
            if (b[i]) r = r ^ (325'(a) << i);
        end
        return r;
    endfunction

    assign b2.mul_y = clmul(b2.mul_a, b2.mul_b);
    assign b4.mul_y = clmul(b4.mul_a, b4.mul_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        assert (MC2 >= 1 && MC2 <= 15) else $error("MUL_CYCLES out of range for u_dut2");
        assert (MC4 >= 1 && MC4 <= 15) else $error("MUL_CYCLES out of range for u_dut4");
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Result monitor for u_dut2: pops the scoreboard on each result handshake
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            n_vec++;
            if (b2.req0_ready && b2.req1_ready) begin
                n_err++;
                $display("FAIL ready_onehot: req0_ready=%0b req1_ready=%0b required not both 1",
                         b2.req0_ready, b2.req1_ready);
            end
            if (b2.res_valid && b2.res_ready) begin
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_result: got y=%0h id=%0b with nothing expected",
                             b2.res_y, b2.res_id);
                end else begin
                    e = sb_q.pop_front();
                    if (b2.res_y !== e.y) begin
                        n_err++;
                        $display("FAIL res_y: got %0h required %0h", b2.res_y, e.y);
                    end
                    n_vec++;
                    if (b2.res_id !== e.id) begin
                        n_err++;
                        $display("FAIL res_id: got %0b required %0b", b2.res_id, e.id);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) tick();
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_timeout: %0d results outstanding, required 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic wait_res_valid(input string name);
        for (int i = 0; i < 50 && !b2.res_valid; i++) tick();
        n_vec++;
        if (b2.res_valid !== 1'b1) begin
            n_err++;
            $display("FAIL %s_res_valid_timeout: res_valid=%0b required 1", name, b2.res_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        n_vec++; if (b2.mul_a !== '0)    begin n_err++; $display("FAIL rst_mul_a: got %0h required 0", b2.mul_a); end
        n_vec++; if (b2.mul_b !== '0)    begin n_err++; $display("FAIL rst_mul_b: got %0h required 0", b2.mul_b); end
        n_vec++; if (b2.res_y !== '0)    begin n_err++; $display("FAIL rst_res_y: got %0h required 0", b2.res_y); end
        n_vec++; if (b2.res_valid !== 1'b0) begin n_err++; $display("FAIL rst_res_valid: got %0b required 0", b2.res_valid); end
        n_vec++; if (b2.res_id !== 1'b0) begin n_err++; $display("FAIL rst_res_id: got %0b required 0", b2.res_id); end
        n_vec++; if (b2.busy !== 1'b0)   begin n_err++; $display("FAIL rst_busy: got %0b required 0", b2.busy); end
        n_vec++; if (b4.busy !== 1'b0)   begin n_err++; $display("FAIL rst_busy4: got %0b required 0", b4.busy); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_op();
        int lat;
        b2.req0_a = 163'd3; b2.req0_b = 163'd3; b2.req0_valid = 1'b1; b2.res_ready = 1'b1;
        #1;
        n_vec++;
        if (b2.req0_ready !== 1'b1) begin n_err++; $display("FAIL single_req0_ready: got %0b required 1", b2.req0_ready); end
        sb_q.push_back('{y: 325'd5, id: 1'b0});
        tick();
        b2.req0_valid = 1'b0;
        // Count edges from the acceptance edge (as 1) up to the one that raises res_valid
        lat = 1;
        while (!b2.res_valid && lat < 20) begin
            tick();
            lat++;
        end
        n_vec++;
        if (lat != int'(MC2) + 1) begin n_err++; $display("FAIL single_latency: got %0d edges required %0d", lat, MC2 + 1); end
        tick();
        n_vec++;
        if (b2.busy !== 1'b0) begin n_err++; $display("FAIL single_busy_after: got %0b required 0", b2.busy); end
        n_vec++;
        if (b2.res_valid !== 1'b0) begin n_err++; $display("FAIL single_res_valid_after: got %0b required 0", b2.res_valid); end
        wait_drain("single");
    endtask

    task automatic test_tie();
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        b2.req0_a = 163'h6; b2.req0_b = 163'h3;
        b2.req1_a = 163'h7; b2.req1_b = 163'h7;
        b2.res_ready = 1'b1;
        sb_q.push_back('{y: 325'hA,  id: 1'b0});
        sb_q.push_back('{y: 325'h15, id: 1'b1});
        sb_q.push_back('{y: 325'hA,  id: 1'b0});
        b2.req0_valid = 1'b1; b2.req1_valid = 1'b1;
        wait_drain("tie");
        b2.req0_valid = 1'b0; b2.req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [324:0] y0;
        logic         id0;
        b2.res_ready = 1'b0;
        b2.req0_a = 163'd5; b2.req0_b = 163'd1; b2.req0_valid = 1'b1;
        sb_q.push_back('{y: 325'h5, id: 1'b0});
        tick();
        b2.req0_valid = 1'b0;
        b2.req1_a = 163'd9; b2.req1_b = 163'd3; b2.req1_valid = 1'b1;
        sb_q.push_back('{y: 325'h1B, id: 1'b1});
        wait_res_valid("bp");
        y0  = b2.res_y;
        id0 = b2.res_id;
        for (int i = 0; i < 10; i++) begin
            n_vec++; if (b2.res_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_held: got %0b required 1", b2.res_valid); end
            n_vec++; if (b2.res_y !== y0)       begin n_err++; $display("FAIL bp_res_y_stable: got %0h required %0h", b2.res_y, y0); end
            n_vec++; if (b2.res_id !== id0)     begin n_err++; $display("FAIL bp_res_id_stable: got %0b required %0b", b2.res_id, id0); end
            n_vec++; if (b2.req1_ready !== 1'b0) begin n_err++; $display("FAIL bp_req1_blocked: got %0b required 0", b2.req1_ready); end
            tick();
        end
        b2.res_ready = 1'b1;
        #1;
        n_vec++;
        if (b2.req1_ready !== 1'b0) begin n_err++; $display("FAIL bp_no_bypass: got %0b required 0", b2.req1_ready); end
        tick();
        n_vec++;
        if (b2.req1_ready !== 1'b1) begin n_err++; $display("FAIL bp_req1_next: got %0b required 1", b2.req1_ready); end
        tick();
        b2.req1_valid = 1'b0;
        wait_drain("bp");
        tick();
    endtask

    task automatic test_reset_mid();
        b2.res_ready = 1'b1;
        b2.req0_a = 163'd3; b2.req0_b = 163'd3; b2.req0_valid = 1'b1;
        tick();
        b2.req0_valid = 1'b0;
        n_vec++;
        if (b2.busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_wait: got %0b required 1", b2.busy); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (b2.mul_a !== '0)       begin n_err++; $display("FAIL mid_mul_a: got %0h required 0", b2.mul_a); end
        n_vec++; if (b2.mul_b !== '0)       begin n_err++; $display("FAIL mid_mul_b: got %0h required 0", b2.mul_b); end
        n_vec++; if (b2.res_y !== '0)       begin n_err++; $display("FAIL mid_res_y: got %0h required 0", b2.res_y); end
        n_vec++; if (b2.res_valid !== 1'b0) begin n_err++; $display("FAIL mid_res_valid: got %0b required 0", b2.res_valid); end
        n_vec++; if (b2.busy !== 1'b0)      begin n_err++; $display("FAIL mid_busy: got %0b required 0", b2.busy); end
        tick();
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (b2.res_valid !== 1'b0) begin n_err++; $display("FAIL mid_no_result: got %0b required 0", b2.res_valid); end
        b2.req0_a = 163'h6; b2.req0_b = 163'h3; b2.req1_a = 163'h7; b2.req1_b = 163'h7;
        b2.req0_valid = 1'b1; b2.req1_valid = 1'b1;
        #1;
        n_vec++; if (b2.req0_ready !== 1'b1) begin n_err++; $display("FAIL mid_req0_first: got %0b required 1", b2.req0_ready); end
        n_vec++; if (b2.req1_ready !== 1'b0) begin n_err++; $display("FAIL mid_req1_wait: got %0b required 0", b2.req1_ready); end
        sb_q.push_back('{y: 325'hA, id: 1'b0});
        tick();
        b2.req0_valid = 1'b0; b2.req1_valid = 1'b0;
        wait_drain("mid");
        tick();
    endtask

    task automatic test_full_width();
        logic [324:0] sq;
        sq = '0;
        for (int i = 0; i <= 162; i++) sq[2*i] = 1'b1;
        b2.res_ready = 1'b1;
        b2.req0_a = '1; b2.req0_b = '1; b2.req0_valid = 1'b1;
        sb_q.push_back('{y: sq, id: 1'b0});
        tick();
        b2.req0_valid = 1'b0;
        wait_drain("full");
        tick();
    endtask

    task automatic test_operand_hold();
        logic [162:0] p;
        logic [324:0] e;
        int           hold;
        p = '0; p[162] = 1'b1;
        e = '0; e[324] = 1'b1;
        b4.res_ready = 1'b1;
        b4.req0_a = p; b4.req0_b = p; b4.req0_valid = 1'b1;
        #1;
        n_vec++;
        if (b4.req0_ready !== 1'b1) begin n_err++; $display("FAIL hold_req0_ready: got %0b required 1", b4.req0_ready); end
        tick();
        b4.req0_valid = 1'b0;
        hold = 0;
        for (int i = 0; i < 30 && !b4.res_valid; i++) begin
            n_vec++;
            if (b4.mul_a !== p || b4.mul_b !== p) begin
                n_err++;
                $display("FAIL hold_operands: got a=%0h b=%0h required %0h", b4.mul_a, b4.mul_b, p);
            end
            hold++;
            b4.req0_a = 163'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
            b4.req0_b = 163'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
            tick();
        end
        n_vec++; if (hold != int'(MC4)) begin n_err++; $display("FAIL hold_cycles: got %0d required %0d", hold, MC4); end
        n_vec++; if (b4.res_valid !== 1'b1) begin n_err++; $display("FAIL hold_res_valid: got %0b required 1", b4.res_valid); end
        n_vec++; if (b4.res_y !== e)        begin n_err++; $display("FAIL hold_res_y: got %0h required %0h", b4.res_y, e); end
        n_vec++; if (b4.res_id !== 1'b0)    begin n_err++; $display("FAIL hold_res_id: got %0b required 0", b4.res_id); end
        tick();
        n_vec++; if (b4.busy !== 1'b0)      begin n_err++; $display("FAIL hold_busy_after: got %0b required 0", b4.busy); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        b2.req0_valid = 1'b0; b2.req0_a = '0; b2.req0_b = '0;
        b2.req1_valid = 1'b0; b2.req1_a = '0; b2.req1_b = '0;
        b2.res_ready  = 1'b0;
        b4.req0_valid = 1'b0; b4.req0_a = '0; b4.req0_b = '0;
        b4.req1_valid = 1'b0; b4.req1_a = '0; b4.req1_b = '0;
        b4.res_ready  = 1'b0;
        test_reset();
        test_single_op();
        test_tie();
        test_backpressure();
        test_reset_mid();
        test_full_width();
        test_operand_hold();
        n_vec++;
        if (sb_q.size() != 0) begin n_err++; $display("FAIL sb_leftover: got %0d required 0", sb_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
